fx_bus_arb: RTL

Two-requester arbiter and sequencer for the fx register bus in the FPGA control path. Requester A is the local command executor (fed by the factory controller's local command stream); requester B is the status/readback poller. The block grants one requester at a time, drives the fx write/read strobes and addresses for exactly one access, captures read data after a fixed bus latency, and returns a completion pulse to the owner.

---
 rtl/fx_bus_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fx_bus_arb.sv
// fx_bus_arb: grants the fx register bus to requester A or B for one access at a time.
// Define FX_ARB_RR_EN for round-robin arbitration; otherwise A has fixed priority on ties.
module fx_bus_arb #(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_done,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_done,
    output logic [7:0]  b_rdata,
    output logic [15:0] fx_waddr,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic        fx_rd,
    output logic [15:0] fx_raddr,
    input  logic [7:0]  fx_q
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);
    localparam logic [1:0] GAP_LOAD = 2'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit         GAP_EN   = (GAP > 0);

    logic [2:0]  state_r;
    logic        owner_r;
    logic [2:0]  lat_cnt_r;
    logic [1:0]  gap_cnt_r;
`ifdef FX_ARB_RR_EN
    logic        last_b_r;
`endif

    logic        req_any_s;
    logic        grant_b_s;
    logic        sel_we_s;
    logic [15:0] sel_addr_s;
    logic [7:0]  sel_wdata_s;

    // Winner selection and operand mux for the IDLE grant decision
    always_comb begin
        req_any_s = a_req | b_req;
`ifdef FX_ARB_RR_EN
        grant_b_s = b_req & (~a_req | ~last_b_r);
`else
        grant_b_s = b_req & ~a_req;
`endif
        sel_we_s    = grant_b_s ? b_we    : a_we;
        sel_addr_s  = grant_b_s ? b_addr  : a_addr;
        sel_wdata_s = grant_b_s ? b_wdata : a_wdata;
    end

    // Access sequencer; strobes and done pulses are loaded one cycle ahead so every output is a flop
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_r   <= S_IDLE;
            owner_r   <= 1'b0;
            lat_cnt_r <= 3'd0;
            gap_cnt_r <= 2'd0;
            fx_waddr  <= 16'h0000;
            fx_raddr  <= 16'h0000;
            fx_data   <= 8'h00;
            fx_wr     <= 1'b0;
            fx_rd     <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            a_rdata   <= 8'h00;
            b_rdata   <= 8'h00;
`ifdef FX_ARB_RR_EN
            last_b_r  <= 1'b1;
`endif
        end else begin
            fx_wr  <= 1'b0;
            fx_rd  <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_any_s) begin
                        owner_r <= grant_b_s;
                        if (sel_we_s) begin
                            fx_wr    <= 1'b1;
                            fx_waddr <= sel_addr_s;
                            fx_data  <= sel_wdata_s;
                            state_r  <= S_WRITE;
                        end else begin
                            fx_rd    <= 1'b1;
                            fx_raddr <= sel_addr_s;
                            state_r  <= S_READ;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    a_done  <= ~owner_r;
                    b_done  <= owner_r;
                    state_r <= S_DONE;
                end
                S_READ: begin
                    lat_cnt_r <= LAT_LOAD;
                    state_r   <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (lat_cnt_r == 3'd0) begin
                        if (owner_r) begin
                            b_rdata <= fx_q;
                        end else begin
                            a_rdata <= fx_q;
                        end
                        a_done  <= ~owner_r;
                        b_done  <= owner_r;
                        state_r <= S_DONE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                S_DONE: begin
`ifdef FX_ARB_RR_EN
                    last_b_r <= owner_r;
`endif
                    if (GAP_EN) begin
                        gap_cnt_r <= GAP_LOAD;
                        state_r   <= S_GAP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r == 2'd0) begin
                        state_r <= S_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
